multiband_image_reader: RTL and testbench

Parametrised successor to the single-band image reader. On a `start` pulse it walks an external synchronous image memory holding `NUM_BANDS` bands of `IMG_SIZE` pixels each. It streams every pixel out through a valid/ready interface, tagged with band and pixel index. Sits between the image store and the compression/processing pipeline. Supports band-sequential or band-interleaved-by-pixel output order and absorbs downstream backpressure without dropping or duplicating words.

---
 rtl/multiband_image_reader.sv | 160 ++++++++++++++++
 tb/tb_multiband_image_reader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multiband_image_reader.sv
`default_nettype none
// ============================================================================
// multiband_image_reader - streams NUM_BANDS x IMG_SIZE pixels from a sync RAM
// in BSQ or BIP order through a 2-entry valid/ready output buffer.
// Revision: 1.0
// ============================================================================
module multiband_image_reader #(
    parameter int DATA_W    = 16,
    parameter int NUM_BANDS = 8,
    parameter int IMG_SIZE  = 1024,
    parameter int BAND_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1,
    parameter int PIX_W     = $clog2(IMG_SIZE),
    parameter int ADDR_W    = $clog2(NUM_BANDS * IMG_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              mode_i,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [BAND_W-1:0] out_band_o,
    output logic [PIX_W-1:0]  out_pix_o,
    output logic              out_last_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [BAND_W-1:0] band;
        logic [PIX_W-1:0]  pix;
        logic              last;
    } entry_t;

    state_t            state_q;
    logic              mode_q, busy_q, done_q, valid_q, inflight_q;
    logic [BAND_W-1:0] band_q, tag_band_q;
    logic [PIX_W-1:0]  pix_q, tag_pix_q;
    logic              tag_last_q;
    logic [1:0]        count_q, count_d;
    entry_t            head_q, tail_q, wr_entry;
    logic              pop, issue, band_end, pix_end, final_rd;

    assign band_end = (band_q == BAND_W'(NUM_BANDS - 1));
    assign pix_end  = (pix_q == PIX_W'(IMG_SIZE - 1));
    assign final_rd = band_end && pix_end;
    assign pop      = valid_q && out_ready_i;
    // Occupancy is taken after this cycle's pop so a fully-ready stream never bubbles.
    assign issue    = (state_q == S_READ) &&
                      (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
    assign wr_entry = {mem_data_i, tag_band_q, tag_pix_q, tag_last_q};

    always_comb begin
        count_d = count_q;
        case ({inflight_q, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            inflight_q <= 1'b0;
            band_q     <= '0;
            pix_q      <= '0;
            tag_band_q <= '0;
            tag_pix_q  <= '0;
            tag_last_q <= 1'b0;
            count_q    <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            inflight_q <= issue;
            count_q    <= count_d;
            valid_q    <= (count_d != 2'd0);
            done_q     <= 1'b0;

            if (issue) begin
                tag_band_q <= band_q;
                tag_pix_q  <= pix_q;
                tag_last_q <= final_rd;
                if (mode_q) begin
                    band_q <= band_end ? '0 : band_q + BAND_W'(1);
                    if (band_end) pix_q <= pix_end ? '0 : pix_q + PIX_W'(1);
                end else begin
                    pix_q <= pix_end ? '0 : pix_q + PIX_W'(1);
                    if (pix_end) band_q <= band_end ? '0 : band_q + BAND_W'(1);
                end
            end

            case ({inflight_q, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= wr_entry;
                    else                 tail_q <= wr_entry;
                end
                2'b01: head_q <= tail_q;
                2'b11: begin
                    head_q <= (count_q == 2'd1) ? wr_entry : tail_q;
                    tail_q <= wr_entry;
                end
                default: ;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_READ;
                        mode_q  <= mode_i;
                        band_q  <= '0;
                        pix_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_READ: begin
                    if (issue && final_rd) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop && head_q.last) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_en_o    = issue;
    assign mem_addr_o  = ADDR_W'(band_q) * ADDR_W'(IMG_SIZE) + ADDR_W'(pix_q);
    assign out_data_o  = head_q.data;
    assign out_band_o  = head_q.band;
    assign out_pix_o   = head_q.pix;
    assign out_last_o  = head_q.last;
    assign out_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_multiband_image_reader.sv
`default_nettype none
// ============================================================================
// tb_multiband_image_reader - scoreboard bench, NUM_BANDS=2, IMG_SIZE=4.
// Revision: 1.0
// ============================================================================
module tb_multiband_image_reader;

    localparam int DW = 16;
    localparam int NB = 2;
    localparam int IS = 4;
    localparam int BW = 1;
    localparam int PW = 2;
    localparam int AW = 3;
    localparam int N  = NB * IS;

    typedef logic [DW+BW+PW:0] exp_t;

    logic          clk = 1'b0;
    logic          rst, start, mode, out_ready;
    logic          mem_en, out_last, out_valid, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data, out_data;
    logic [BW-1:0] out_band;
    logic [PW-1:0] out_pix;

    always #5 clk = ~clk;

    multiband_image_reader #(
        .DATA_W   (DW),
        .NUM_BANDS(NB),
        .IMG_SIZE (IS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .mode_i     (mode),
        .mem_en_o   (mem_en),
        .mem_addr_o (mem_addr),
        .mem_data_i (mem_data),
        .out_data_o (out_data),
        .out_band_o (out_band),
        .out_pix_o  (out_pix),
        .out_last_o (out_last),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .busy_o     (busy),
        .done_o     (done)
    );

    always_ff @(posedge clk) if (mem_en) mem_data <= 16'h0100 + 16'(mem_addr);

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, t0 = 0, first_valid = -1, done_cnt = 0, done_rel = -1, n_xfer = 0;
    int   iss_cum = 0, iss_prev = 0, hs_cum = 0;
    bit   mon_en = 1'b0, prev_stall = 1'b0;
    exp_t snap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic tick();
        exp_t got, ex;
        int   occ;
        logic hs, en;
        #1;
        occ = iss_prev - hs_cum;
        got = {out_data, out_band, out_pix, out_last};
        if (mon_en) begin
            check("occ_valid", 32'(out_valid), 32'(occ != 0));
            if (occ >= 2 && !out_ready) check("mem_en_full", 32'(mem_en), 32'd0);
            if (prev_stall) check("stable", 32'(got), 32'(snap));
            if (out_valid && out_ready) begin
                ex = 'x;
                if (sb.size() != 0) ex = sb.pop_front();
                check("word", 32'(got), 32'(ex));
                n_xfer++;
            end
            if (done) begin
                done_cnt++;
                done_rel = cyc - t0;
            end
            if (out_valid && first_valid < 0) first_valid = cyc - t0;
        end
        prev_stall = out_valid && !out_ready;
        snap = got;
        hs = out_valid && out_ready;
        en = mem_en;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        iss_prev = iss_cum;
        iss_cum += int'(en);
        hs_cum += int'(hs);
        if (rst) begin
            iss_cum = 0; iss_prev = 0; hs_cum = 0;
            prev_stall = 1'b0;
            sb.delete();
        end
    endtask

    task automatic push_frame(input logic m);
        for (int o = 0; o < (m ? IS : NB); o++) begin
            for (int i = 0; i < (m ? NB : IS); i++) begin
                int b, p;
                b = m ? i : o;
                p = m ? o : i;
                sb.push_back({16'(16'h0100 + b * IS + p), BW'(b), PW'(p),
                              (b == NB - 1 && p == IS - 1)});
            end
        end
    endtask

    task automatic start_frame(input logic m);
        push_frame(m);
        start = 1'b1;
        mode = m;
        t0 = cyc;
        first_valid = -1;
        done_cnt = 0;
        done_rel = -1;
        n_xfer = 0;
        tick();
        start = 1'b0;
    endtask

    // rmode 0: ready held high; 1: ready pattern 1,0,0 repeating
    task automatic run_frame(input logic m, input int rmode, input bit repulse);
        start_frame(m);
        for (int r = 1; r <= 80 && done_cnt == 0; r++) begin
            out_ready = (rmode == 0) ? 1'b1 : ((r % 3) == 1);
            start = repulse && (r == 4 || r == 9);
            mode = repulse ? ~m : m;
            if (r == 1) begin
                #1;
                check("first_en", 32'(mem_en), 32'd1);
                check("first_addr", 32'(mem_addr), 32'd0);
                check("busy_run", 32'(busy), 32'd1);
            end
            if (r == 2) check("addr2", 32'(mem_addr), m ? 32'd4 : 32'd1);
            tick();
        end
        start = 1'b0;
        mode = m;
        out_ready = 1'b1;
        check("done_seen", 32'(done_cnt), 32'd1);
        check("xfers", 32'(n_xfer), 32'(N));
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("first_valid", 32'(first_valid), 32'd3);
        if (rmode == 0) check("done_cycle", 32'(done_rel), 32'(N + 3));
        #1;
        check("busy_fall", 32'(busy), 32'd0);
        check("valid_idle", 32'(out_valid), 32'd0);
        tick();
        tick();
        check("single_done", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_outs", 32'({out_data, out_band, out_pix, out_last}), 32'd0);
        mon_en = 1'b1;

        run_frame(1'b0, 0, 1'b0);   // BSQ streaming
        run_frame(1'b1, 0, 1'b0);   // BIP streaming
        run_frame(1'b0, 1, 1'b0);   // BSQ under backpressure
        run_frame(1'b1, 0, 1'b1);   // start re-pulsed mid-frame, mode flipped

        // reset in the middle of a frame
        start_frame(1'b0);
        for (int r = 1; r <= 4; r++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_mem_en", 32'(mem_en), 32'd0);
        for (int r = 0; r < 6; r++) tick();
        check("mrst_no_done", 32'(done_cnt), 32'd0);
        run_frame(1'b0, 0, 1'b0);

        // back-to-back: start in DONE ignored, start one cycle later accepted
        start_frame(1'b0);
        for (int r = 1; r <= N + 2; r++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("b2b_done", 32'(done_cnt), 32'd1);
        check("b2b_idle", 32'(busy), 32'd0);
        run_frame(1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
